// File: rtl/ysyx_22050019_pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates the shared memory bus between fetch and load/store,
// and derives per-stage stall/flush controls from bus occupancy, load-use hazards and EX redirects.
module ysyx_22050019_pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ifu_req_i,
    output logic             ifu_done_o,
    input  logic             lsu_req_i,
    output logic             lsu_done_o,
    output logic             bus_req_o,
    output logic             bus_sel_o,
    input  logic             bus_ack_i,
    input  logic             bus_done_i,
    input  logic             idex_ram_re_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             ifid_rs1_en_i,
    input  logic             ifid_rs2_en_i,
    input  logic             ex_jump_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mem_stall_o,
    output logic             mem_wb_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] perf_mem_stall_o,
    output logic [CNT_W-1:0] perf_luse_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        LS_REQ  = 3'd3,
        LS_WAIT = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   kill, kill_nxt;

    logic ls_done, if_done;
    logic lsu_busy, fetch_busy;
    logic load_use, advance, kill_eff;
    logic in_fetch;

    // Done is recognised in the REQ state only when the same cycle also carries the ack.
    assign ls_done  = bus_done_i & (((state == LS_REQ) & bus_ack_i) | (state == LS_WAIT));
    assign if_done  = bus_done_i & (((state == IF_REQ) & bus_ack_i) | (state == IF_WAIT));
    assign in_fetch = (state == IF_REQ) | (state == IF_WAIT);

    assign load_use = idex_ram_re_i & (idex_rd_i != 5'd0) &
                      ((ifid_rs1_en_i & (ifid_rs1_i == idex_rd_i)) |
                       (ifid_rs2_en_i & (ifid_rs2_i == idex_rd_i)));

    assign lsu_busy   = lsu_req_i & ~ls_done;
    assign advance    = ex_jump_i & ~lsu_busy;
    assign kill_eff   = kill | advance;
    assign ifu_done_o = if_done & ~kill_eff;
    assign lsu_done_o = ls_done;
    assign fetch_busy = ifu_req_i & ~ifu_done_o;

    // Stalls are nested downstream-to-upstream so a stalled stage feeding a moving one yields a bubble.
    assign mem_wb_stall_o = 1'b0;
    assign ex_mem_stall_o = lsu_busy;
    assign id_ex_stall_o  = lsu_busy | load_use;
    assign if_id_stall_o  = id_ex_stall_o | fetch_busy;
    assign pc_stall_o     = if_id_stall_o;
    assign if_id_flush_o  = advance;
    assign id_ex_flush_o  = advance;

    assign bus_req_o = (state == IF_REQ) | (state == LS_REQ);
    assign bus_sel_o = (state == LS_REQ) | (state == LS_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lsu_req_i)      state_nxt = LS_REQ;
                else if (ifu_req_i) state_nxt = IF_REQ;
            end
            IF_REQ: begin
                if (bus_ack_i & bus_done_i) state_nxt = IDLE;
                else if (bus_ack_i)         state_nxt = IF_WAIT;
            end
            IF_WAIT: if (bus_done_i) state_nxt = IDLE;
            LS_REQ: begin
                if (bus_ack_i & bus_done_i) state_nxt = IDLE;
                else if (bus_ack_i)         state_nxt = LS_WAIT;
            end
            LS_WAIT: if (bus_done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A redirect during an in-flight fetch marks its response stale until it returns.
    always_comb begin
        kill_nxt = kill;
        if (if_done)                  kill_nxt = 1'b0;
        else if (advance & in_fetch)  kill_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            perf_mem_stall_o <= '0;
            perf_luse_o      <= '0;
        end else begin
            perf_mem_stall_o <= perf_mem_stall_o + {{(CNT_W-1){1'b0}}, ex_mem_stall_o};
            perf_luse_o      <= perf_luse_o + {{(CNT_W-1){1'b0}}, (load_use & ~lsu_busy)};
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_pipe_ctrl.sv
// Bench for ysyx_22050019_pipe_ctrl: combinational vector table, directed sequences, random run vs model.
module tb_ysyx_22050019_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, lsu_req, bus_ack, bus_done;
    logic        idex_ram_re, rs1_en, rs2_en, ex_jump;
    logic [4:0]  idex_rd, rs1, rs2;
    logic        ifu_done, lsu_done, bus_req, bus_sel;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic        if_id_flush, id_ex_flush;
    logic [31:0] perf_mem, perf_luse;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22050019_pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_i(ifu_req), .ifu_done_o(ifu_done),
        .lsu_req_i(lsu_req), .lsu_done_o(lsu_done),
        .bus_req_o(bus_req), .bus_sel_o(bus_sel),
        .bus_ack_i(bus_ack), .bus_done_i(bus_done),
        .idex_ram_re_i(idex_ram_re), .idex_rd_i(idex_rd),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
        .ifid_rs1_en_i(rs1_en), .ifid_rs2_en_i(rs2_en),
        .ex_jump_i(ex_jump),
        .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .id_ex_stall_o(id_ex_stall),
        .ex_mem_stall_o(ex_mem_stall), .mem_wb_stall_o(mem_wb_stall),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .perf_mem_stall_o(perf_mem), .perf_luse_o(perf_luse)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb stall, if_id flush, id_ex flush, ifu_done, lsu_done, bus_req, bus_sel}
    wire [10:0] dut_bits = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                            if_id_flush, id_ex_flush, ifu_done, lsu_done, bus_req, bus_sel};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req = 0; lsu_req = 0; bus_ack = 0; bus_done = 0;
        idex_ram_re = 0; idex_rd = 0; rs1 = 0; rs2 = 0;
        rs1_en = 0; rs2_en = 0; ex_jump = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1;
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
    endtask

    typedef struct {
        logic       lsu, ifu, re;
        logic [4:0] rd, r1, r2;
        logic       e1, e2, jmp;
        logic [6:0] exp; // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    } vec_t;

    vec_t vecs[10];

    // Behavioural model: who owns the bus, whether the request was accepted, stale-fetch flag.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    bit          m_acked, m_kill;
    int unsigned m_mem, m_luse;

    function automatic logic [10:0] model_out();
        bit done_now, lsd, ifd, busy, lu, adv, ifdo, fbusy, exm, idx, ifs;
        done_now = (m_owner != 0) && bus_done && (m_acked || bus_ack);
        lsd   = done_now && (m_owner == 2);
        ifd   = done_now && (m_owner == 1);
        busy  = lsu_req && !lsd;
        lu    = idex_ram_re && (idex_rd != 0) &&
                ((rs1_en && rs1 == idex_rd) || (rs2_en && rs2 == idex_rd));
        adv   = ex_jump && !busy;
        ifdo  = ifd && !(m_kill || adv);
        fbusy = ifu_req && !ifdo;
        exm   = busy;
        idx   = busy || lu;
        ifs   = idx || fbusy;
        return {ifs, ifs, idx, exm, 1'b0, adv, adv, ifdo, lsd,
                (m_owner != 0) && !m_acked, m_owner == 2};
    endfunction

    task automatic model_step();
        bit done_now, busy, lu, adv, ifd;
        done_now = (m_owner != 0) && bus_done && (m_acked || bus_ack);
        ifd  = done_now && (m_owner == 1);
        busy = lsu_req && !(done_now && m_owner == 2);
        lu   = idex_ram_re && (idex_rd != 0) &&
               ((rs1_en && rs1 == idex_rd) || (rs2_en && rs2 == idex_rd));
        adv  = ex_jump && !busy;
        if (busy) m_mem++;
        if (lu && !busy) m_luse++;
        if (ifd) m_kill = 0;
        else if (adv && m_owner == 1) m_kill = 1;
        if (m_owner == 0) begin
            m_acked = 0;
            if (lsu_req) m_owner = 2;
            else if (ifu_req) m_owner = 1;
        end else if (done_now) begin
            m_owner = 0;
            m_acked = 0;
        end else if (bus_ack) begin
            m_acked = 1;
        end
    endtask

    initial begin
        vecs[0] = '{0,0,0, 0,0,0, 0,0,0, 7'b0000000};
        vecs[1] = '{1,0,0, 0,0,0, 0,0,0, 7'b1111000};
        vecs[2] = '{0,1,0, 0,0,0, 0,0,0, 7'b1100000};
        vecs[3] = '{0,0,1, 5,0,5, 0,1,0, 7'b1110000};
        vecs[4] = '{0,0,1, 0,0,0, 1,1,0, 7'b0000000};
        vecs[5] = '{0,0,1, 7,7,0, 0,0,0, 7'b0000000};
        vecs[6] = '{0,0,1, 7,7,0, 1,0,0, 7'b1110000};
        vecs[7] = '{0,0,0, 0,0,0, 0,0,1, 7'b0000011};
        vecs[8] = '{1,0,0, 0,0,0, 0,0,1, 7'b1111000};
        vecs[9] = '{0,0,0, 5,5,5, 1,1,0, 7'b0000000};

        clear_inputs();
        do_reset();
        chk("reset_outputs", {21'b0, dut_bits}, 32'd0);
        chk("reset_perf_mem", perf_mem, 32'd0);
        chk("reset_perf_luse", perf_luse, 32'd0);

        // Combinational table, each from a fresh IDLE state.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            lsu_req = vecs[i].lsu; ifu_req = vecs[i].ifu; idex_ram_re = vecs[i].re;
            idex_rd = vecs[i].rd; rs1 = vecs[i].r1; rs2 = vecs[i].r2;
            rs1_en = vecs[i].e1; rs2_en = vecs[i].e2; ex_jump = vecs[i].jmp;
            #1;
            chk($sformatf("vec%0d", i), {21'b0, dut_bits}, {21'b0, vecs[i].exp, 4'b0000});
        end

        // Load: ack one cycle after request, done two cycles after that.
        do_reset();
        lsu_req = 1; #1;
        chk("ld_c0_exmem", ex_mem_stall, 1);
        tick(); bus_ack = 1; #1;
        chk("ld_c1_req_sel", {bus_req, bus_sel}, 2'b11);
        tick(); bus_ack = 0; #1;
        chk("ld_c2_stall_nodone", {ex_mem_stall, lsu_done}, 2'b10);
        tick(); bus_done = 1; #1;
        chk("ld_c3_release", {ex_mem_stall, lsu_done}, 2'b01);
        tick(); bus_done = 0; lsu_req = 0; #1;
        chk("ld_after_idle", {lsu_done, bus_req}, 2'b00);
        chk("ld_perf_mem", perf_mem, 32'd3);

        // Simultaneous requests: data wins, fetch follows.
        do_reset();
        lsu_req = 1; ifu_req = 1; #1;
        chk("arb_c0_ifid", {if_id_stall, bus_req}, 2'b10);
        tick(); bus_ack = 1; bus_done = 1; #1;
        chk("arb_c1_ls", {bus_req, bus_sel, lsu_done, if_id_stall}, 4'b1111);
        tick(); lsu_req = 0; bus_ack = 0; bus_done = 0; #1;
        chk("arb_c2_idle", {bus_req, if_id_stall}, 2'b01);
        tick(); bus_ack = 1; bus_done = 1; #1;
        chk("arb_c3_fetch", {bus_req, bus_sel, ifu_done, if_id_stall}, 4'b1010);
        tick(); clear_inputs();

        // Load-use bubble and the rd=0 exemption.
        do_reset();
        idex_ram_re = 1; idex_rd = 5; rs2 = 5; rs2_en = 1; #1;
        chk("lu_stall", {id_ex_stall, ex_mem_stall}, 2'b10);
        tick(); idex_rd = 0; rs2 = 0; #1;
        chk("lu_count", perf_luse, 32'd1);
        chk("lu_rd0", id_ex_stall, 0);
        tick(); #1;
        chk("lu_rd0_count", perf_luse, 32'd1);
        clear_inputs();

        // Redirect during IF_WAIT kills the response.
        do_reset();
        ifu_req = 1;
        tick(); bus_ack = 1; #1;
        chk("kill_req", bus_req, 1);
        tick(); bus_ack = 0; ex_jump = 1; #1;
        chk("kill_flush", {if_id_flush, id_ex_flush}, 2'b11);
        tick(); ex_jump = 0; bus_done = 1; #1;
        chk("kill_done_masked", ifu_done, 0);
        tick(); bus_done = 0; #1;
        chk("kill_idle", bus_req, 0);
        tick(); bus_ack = 1; bus_done = 1; #1;
        chk("kill_cleared", ifu_done, 1);
        tick(); clear_inputs();

        // Redirect held behind a busy load.
        do_reset();
        lsu_req = 1; ex_jump = 1; #1;
        chk("jl_c0_noflush", {if_id_flush, id_ex_flush}, 2'b00);
        tick(); bus_ack = 1; #1;
        chk("jl_c1_noflush", {if_id_flush, id_ex_flush}, 2'b00);
        tick(); bus_ack = 0; bus_done = 1; #1;
        chk("jl_done_flush", {if_id_flush, id_ex_flush, lsu_done}, 3'b111);
        tick(); clear_inputs();

        // Asynchronous reset mid-transaction.
        do_reset();
        lsu_req = 1;
        tick(); bus_ack = 1;
        tick(); bus_ack = 0; #1;
        chk("rst_pre_sel", {bus_req, bus_sel}, 2'b01);
        rst_n = 1; #1;
        chk("rst_async_bus", {bus_req, bus_sel}, 2'b00);
        chk("rst_async_cnt", perf_mem, 32'd0);
        lsu_req = 0; #1;
        rst_n = 0;

        // Random run against the model.
        do_reset();
        m_owner = 0; m_acked = 0; m_kill = 0; m_mem = 0; m_luse = 0;
        for (int c = 0; c < 3000; c++) begin
            lsu_req     = ($urandom_range(0, 3) == 0);
            ifu_req     = ($urandom_range(0, 1) == 0);
            bus_ack     = ($urandom_range(0, 1) == 0);
            bus_done    = ($urandom_range(0, 2) == 0);
            idex_ram_re = ($urandom_range(0, 1) == 0);
            idex_rd     = 5'($urandom_range(0, 3));
            rs1         = 5'($urandom_range(0, 3));
            rs2         = 5'($urandom_range(0, 3));
            rs1_en      = ($urandom_range(0, 1) == 0);
            rs2_en      = ($urandom_range(0, 1) == 0);
            ex_jump     = ($urandom_range(0, 4) == 0);
            #1;
            if (c % 10 == 0) begin
                chk($sformatf("rnd%0d_bits", c), {21'b0, dut_bits}, {21'b0, model_out()});
                chk($sformatf("rnd%0d_mem", c), perf_mem, m_mem);
                chk($sformatf("rnd%0d_luse", c), perf_luse, m_luse);
            end else if (dut_bits !== model_out()) begin
                chk($sformatf("rnd%0d_bits", c), {21'b0, dut_bits}, {21'b0, model_out()});
            end
            model_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
